// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: tracks the EXE..WB destinations and produces the EXE operand selects and the ID stall request.
// FORWARDING_EN defined: forward from MEM..WB and stall only on load-use; undefined: no forwarding, stall until the writer reaches WB.
module forwarding_hazard_unit #(
  parameter int NUM_SRC = 3,
  parameter int NUM_FWD = 2,
  parameter int ADDR_LEN = 5,
  localparam int SEL_LEN = $clog2(NUM_FWD + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic [NUM_SRC*ADDR_LEN-1:0] src_ID,
  input  logic [NUM_SRC-1:0]          src_used_ID,
  input  logic [ADDR_LEN-1:0]         dest_ID,
  input  logic                        WB_EN_ID,
  input  logic                        MEM_R_EN_ID,
  output logic                        hazard_detected,
  output logic [NUM_SRC*SEL_LEN-1:0]  sel
);
  // Without forwarding the WB entry never matters, so the tracked pipe stops one stage short.
  localparam int LAST = `ifdef FORWARDING_EN NUM_FWD `else NUM_FWD - 1 `endif;
  logic [ADDR_LEN-1:0] dest [LAST+1];
  logic [LAST:0] wb_en;
  logic bubble;
  assign bubble = hazard_detected | flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k <= LAST; k++) dest[k] <= '0;
      wb_en <= '0;
    end else if (!freeze) begin
      for (int k = LAST; k > 0; k--) dest[k] <= dest[k-1];
      dest[0] <= bubble ? '0 : dest_ID;
      wb_en <= {wb_en[LAST-1:0], WB_EN_ID & ~bubble};
    end
`ifdef FORWARDING_EN
  logic mem_r_en;
  logic [NUM_SRC*ADDR_LEN-1:0] src_exe;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_r_en <= 1'b0;
      src_exe <= '0;
    end else if (!freeze) begin
      mem_r_en <= MEM_R_EN_ID & ~bubble;
      src_exe <= bubble ? '0 : src_ID;
    end
  always_comb begin
    hazard_detected = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_r_en && dest[0] != '0 && src_used_ID[i] && src_ID[i*ADDR_LEN +: ADDR_LEN] == dest[0])
        hazard_detected = 1'b1;
      // Scanning oldest to youngest lets the youngest matching writer overwrite.
      for (int k = NUM_FWD; k >= 1; k--)
        if (wb_en[k] && dest[k] != '0 && dest[k] == src_exe[i*ADDR_LEN +: ADDR_LEN])
          sel[i*SEL_LEN +: SEL_LEN] = SEL_LEN'(k);
    end
  end
`else
  logic unused_load;
  assign unused_load = MEM_R_EN_ID;
  assign sel = '0;
  always_comb begin
    hazard_detected = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k <= LAST; k++)
        if (wb_en[k] && dest[k] != '0 && src_used_ID[i] && src_ID[i*ADDR_LEN +: ADDR_LEN] == dest[k])
          hazard_detected = 1'b1;
  end
`endif
endmodule
